// File: rtl/div32s.sv
// div32s: sequential radix-2 non-restoring N-bit divider, signed/unsigned per operation.
// Define DIV32S_EARLY_OUT_EN to bypass the iterations when b == 0 or |a| < |b|.
module div32s #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quo,
    output logic [N-1:0] rem,
    output logic         dz
);

    localparam int CW = $clog2(N + 1);
    localparam int PW = N + 2;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] part_q, part_d;
    logic [N-1:0]  quot_q, quot_d;
    logic [N-1:0]  divisor_q, divisor_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          signed_q, signed_d;
    logic          negA_q, negA_d;
    logic          negB_q, negB_d;
    logic          bZero_q, bZero_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          outValid_q, outValid_d;

    logic [N-1:0]  aMag, bMag;
    logic [PW-1:0] shifted, divExt, stepRem;
    logic [N-1:0]  remMag;
    logic          quoNeg, remNeg;

    // Magnitudes are unsigned N-bit, so |-2^(N-1)| fits; the partial remainder
    // carries two extra bits for its sign and the doubled range.
    assign aMag    = (mode & a[N-1]) ? (~a + 1'b1) : a;
    assign bMag    = (mode & b[N-1]) ? (~b + 1'b1) : b;
    assign divExt  = {2'b00, divisor_q};
    assign shifted = {part_q[PW-2:0], quot_q[N-1]};
    assign stepRem = part_q[PW-1] ? (shifted + divExt) : (shifted - divExt);
    assign remMag  = part_q[PW-1] ? (part_q[N-1:0] + divisor_q) : part_q[N-1:0];
    assign quoNeg  = signed_q & (negA_q ^ negB_q) & ~bZero_q;
    assign remNeg  = signed_q & negA_q;

    assign in_ready  = rst & (state_q == IDLE);
    assign out_valid = outValid_q;
    assign quo       = quo_q;
    assign rem       = rem_q;
    assign dz        = dz_q;

    // Next-state and datapath selection for the four-state controller.
    always_comb begin
        state_d    = state_q;
        part_d     = part_q;
        quot_d     = quot_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        signed_d   = signed_q;
        negA_d     = negA_q;
        negB_d     = negB_q;
        bZero_d    = bZero_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        outValid_d = outValid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    signed_d  = mode;
                    negA_d    = a[N-1];
                    negB_d    = b[N-1];
                    bZero_d   = (b == '0);
                    quot_d    = aMag;
                    divisor_d = bMag;
                    part_d    = '0;
                    cnt_d     = CW'(N);
                    state_d   = CALC;
                end
            end
            CALC: begin
                part_d = stepRem;
                quot_d = {quot_q[N-2:0], ~stepRem[PW-1]};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = FIX;
                end
`ifdef DIV32S_EARLY_OUT_EN
                // Compare on the registered magnitudes to keep abs+compare off the input path.
                if (cnt_q == CW'(N) && (bZero_q || quot_q < divisor_q)) begin
                    part_d  = {2'b00, quot_q};
                    quot_d  = bZero_q ? '1 : '0;
                    state_d = FIX;
                end
`endif
            end
            FIX: begin
                quo_d      = quoNeg ? (~quot_q + 1'b1) : quot_q;
                rem_d      = remNeg ? (~remMag + 1'b1) : remMag;
                dz_d       = bZero_q;
                outValid_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            part_q     <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            signed_q   <= 1'b0;
            negA_q     <= 1'b0;
            negB_q     <= 1'b0;
            bZero_q    <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            part_q     <= part_d;
            quot_q     <= quot_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            signed_q   <= signed_d;
            negA_q     <= negA_d;
            negB_q     <= negB_d;
            bZero_q    <= bZero_d;
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            outValid_q <= outValid_d;
        end
    end

endmodule

// File: tb/tb_div32s.sv
// tb_div32s: directed-vector bench for div32s with a queue-based scoreboard and
// an independent output monitor.
module tb_div32s;

    typedef struct {
        logic [31:0] quo;
        logic [31:0] rem;
        logic        dz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [31:0] inA;
    logic [31:0] inB;
    logic        inMode;
    logic        outValid;
    logic        outReady;
    logic [31:0] outQuo;
    logic [31:0] outRem;
    logic        outDz;

    exp_t expQ[$];
    int   vectors     = 0;
    int   miscompares = 0;

    div32s #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (inA),
        .b         (inB),
        .mode      (inMode),
        .out_valid (outValid),
        .out_ready (outReady),
        .quo       (outQuo),
        .rem       (outRem),
        .dz        (outDz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("quo", outQuo, e.quo);
                checkOutput("rem", outRem, e.rem);
                checkOutput("dz", {31'd0, outDz}, {31'd0, e.dz});
            end
        end
    end

    // Issue one operation, scramble operands during CALC, and check latency.
    task automatic applyStimulus(input logic m, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] eq, input logic [31:0] er, input logic edz);
        int waitCnt;
        int edges;
        exp_t e;
        waitCnt = 0;
        while (!inReady && waitCnt < 50) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("in_ready before issue", {31'd0, inReady}, 32'd1);
        inMode  = m;
        inA     = av;
        inB     = bv;
        inValid = 1'b1;
        e.quo = eq;
        e.rem = er;
        e.dz  = edz;
        expQ.push_back(e);
        @(posedge clk); #1;
        inValid = 1'b0;
        edges   = 0;
        while (edges < 100) begin
            inA    = $urandom;
            inB    = $urandom;
            inMode = ~inMode;
            @(posedge clk); #1;
            edges++;
            if (outValid) break;
        end
        checkOutput("latency", 32'(edges), 32'd33);
    endtask

    initial begin
        int edgeCnt;
        logic sawValid;
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic sawValid;
        rst      = 1'b1;
        inValid  = 1'b0;
        inA      = '0;
        inB      = '0;
        inMode   = 1'b0;
        outReady = 1'b1;
        #2 rst = 1'b0;
        #1;
        checkOutput("reset out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("reset quo", outQuo, 32'd0);
        checkOutput("reset rem", outRem, 32'd0);
        checkOutput("reset dz", {31'd0, outDz}, 32'd0);
        checkOutput("reset in_ready", {31'd0, inReady}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0);
        applyStimulus(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0);
        applyStimulus(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0);
        applyStimulus(1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1);
        applyStimulus(1'b1, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF0,  1'b1);
        applyStimulus(1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0);
        applyStimulus(1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0);
        applyStimulus(1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0);
        applyStimulus(1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0);
        applyStimulus(1'b0, 32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF,  32'hF,          1'b0);
        applyStimulus(1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0);
        applyStimulus(1'b0, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0);

        // Backpressure: hold the result for 10 cycles while offering a new operation.
        @(posedge clk); #1;
        outReady = 1'b0;
        applyStimulus(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);
        for (int i = 0; i < 10; i++) begin
            inValid = 1'b1;
            inA     = 32'd55;
            inB     = 32'd5;
            inMode  = 1'b0;
            checkOutput("hold out_valid", {31'd0, outValid}, 32'd1);
            checkOutput("hold quo", outQuo, 32'd30);
            checkOutput("hold rem", outRem, 32'd10);
            checkOutput("hold in_ready", {31'd0, inReady}, 32'd0);
            @(posedge clk); #1;
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("post-handshake out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("post-handshake in_ready", {31'd0, inReady}, 32'd1);
        checkOutput("post-handshake quo kept", outQuo, 32'd30);

        // Reset at edge 15 of CALC: discard the operation, no stale result afterwards.
        inMode  = 1'b0;
        inA     = 32'd77;
        inB     = 32'd3;
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (15) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("mid-reset out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("mid-reset quo", outQuo, 32'd0);
        checkOutput("mid-reset rem", outRem, 32'd0);
        checkOutput("mid-reset dz", {31'd0, outDz}, 32'd0);
        checkOutput("mid-reset in_ready", {31'd0, inReady}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("after-reset in_ready", {31'd0, inReady}, 32'd1);
        sawValid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (outValid) sawValid = 1'b1;
        end
        checkOutput("no stale result", {31'd0, sawValid}, 32'd0);

        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
